// File: rtl/v35_bus_arbiter.sv
// Two-master arbiter for the V35 sound-CPU external memory bus: WTC wait states,
// one access at a time, round-robin on simultaneous requests, one-clock ack.
// state | meaning
// IDLE  | strobes low, sample requests and latch the winner
// WAIT  | strobe asserted, count programmed wait states on ce_cycle
// XFER  | strobe held until mem_ready
// DONE  | ack pulse to the granted port, record last grant
module v35_bus_arbiter #(
   parameter int ADDR_W     = 20,
   parameter int DATA_W     = 16,
   parameter int B_USES_WTC = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ce_cycle,
   input  logic [15:0]         wtc,
   input  logic                a_req,
   input  logic                a_we,
   input  logic [DATA_W/8-1:0] a_be,
   input  logic [ADDR_W-1:0]   a_addr,
   input  logic [DATA_W-1:0]   a_wdata,
   output logic                a_ack,
   output logic [DATA_W-1:0]   a_rdata,
   input  logic                b_req,
   input  logic                b_we,
   input  logic [DATA_W/8-1:0] b_be,
   input  logic [ADDR_W-1:0]   b_addr,
   input  logic [DATA_W-1:0]   b_wdata,
   output logic                b_ack,
   output logic [DATA_W-1:0]   b_rdata,
   output logic                mem_rd,
   output logic                mem_wr,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_dout,
   input  logic [DATA_W-1:0]   mem_din,
   input  logic                mem_ready
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_XFER = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0] state;
   logic       last_b;
   logic       gnt_b;
   logic       we_q;
   logic [1:0] wait_cnt;
   logic       pick_b;
   logic [1:0] a_waits;
   logic [1:0] b_waits;
   logic       unused_wtc;

   // Regions 6 and 7 share one field; wtc[15:14] is reserved.
   function automatic logic [1:0] region_waits(input logic [2:0] rg, input logic [15:0] w);
      if (rg >= 3'd6) return w[13:12];
      else            return w[{rg, 1'b0} +: 2];
   endfunction

   assign unused_wtc = ^wtc[15:14];

   always_comb begin
      a_waits = region_waits(a_addr[ADDR_W-1 -: 3], wtc);
      b_waits = (B_USES_WTC != 0) ? region_waits(b_addr[ADDR_W-1 -: 3], wtc) : 2'd0;
      pick_b  = b_req && (!a_req || !last_b);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         last_b   <= 1'b1;
         gnt_b    <= 1'b0;
         we_q     <= 1'b0;
         wait_cnt <= 2'd0;
         mem_rd   <= 1'b0;
         mem_wr   <= 1'b0;
         mem_be   <= '0;
         mem_addr <= '0;
         mem_dout <= '0;
         a_ack    <= 1'b0;
         b_ack    <= 1'b0;
         a_rdata  <= '0;
         b_rdata  <= '0;
      end else begin
         a_ack <= 1'b0;
         b_ack <= 1'b0;
         case (state)
            S_IDLE: begin
               if (a_req || b_req) begin
                  gnt_b    <= pick_b;
                  we_q     <= pick_b ? b_we : a_we;
                  mem_be   <= pick_b ? b_be : a_be;
                  mem_addr <= pick_b ? b_addr : a_addr;
                  mem_dout <= pick_b ? b_wdata : a_wdata;
                  wait_cnt <= pick_b ? b_waits : a_waits;
                  mem_rd   <= pick_b ? !b_we : !a_we;
                  mem_wr   <= pick_b ? b_we : a_we;
                  state    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (wait_cnt == 2'd0) state <= S_XFER;
               else if (ce_cycle)    wait_cnt <= wait_cnt - 2'd1;
            end
            S_XFER: begin
               if (mem_ready) begin
                  mem_rd <= 1'b0;
                  mem_wr <= 1'b0;
                  state  <= S_DONE;
                  if (gnt_b) b_ack <= 1'b1;
                  else       a_ack <= 1'b1;
                  if (!we_q) begin
                     if (gnt_b) b_rdata <= mem_din;
                     else       a_rdata <= mem_din;
                  end
               end
            end
            default: begin
               last_b <= gnt_b;
               state  <= S_IDLE;
            end
         endcase
      end
   end

endmodule
